fp_wb_ctl: RTL and testbench
============================

Name: fp_wb_ctl

Overview:
Writeback and scoreboard stage directly downstream of the FP execute controller (exu_fp_ctl).
- Holds the destination register of the single in-flight FP add/mul/div.
- Captures the result the cycle after the finish pulse and queues it.
- Drains the queue into the shared integer register-file write port whenever the integer pipe is not using it.
- Gates FP issue and flags read-after-write hazards on in-flight or queued destinations.

Parameters:
DEPTH, 2, result-queue entries (power of 2, at least 2).
AW, 5, register address width.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  FP op issued to execute this cycle (same cycle as fp_add/fp_mul/fp_div)
issue_rd  in  AW  destination register of issued op
issue_ready  out  1  FP issue permitted this cycle
fp_finish  in  1  finish pulse from FP execute
fp_result  in  32  FP execute result; valid the cycle after fp_finish
wb_port_busy  in  1  integer pipe owns register-file write port this cycle
wb_en  out  1  FP writeback this cycle
wb_addr  out  AW  writeback register
wb_data  out  32  writeback data
rs1_addr  in  AW  source 1 of instruction in decode
rs2_addr  in  AW  source 2 of instruction in decode
dep_stall  out  1  decode instruction depends on pending FP result
err  out  1  sticky protocol-error flag

Behaviour:
- State:
  - in-flight valid bit and in-flight rd.
  - capture-pending bit (fp_finish registered).
  - circular queue of DEPTH {rd, data} entries, with read pointer, write pointer and count (AW-independent, clog2(DEPTH)+1 bits).
  - err bit.
- Reset (rst high at a clk edge) clears all state: in-flight, capture-pending, count, pointers, err all 0. Outputs after reset: issue_ready=1, wb_en=0, dep_stall=0, err=0. wb_addr/wb_data show the head entry (don't-care while wb_en=0).
- Reset mid-operation discards the in-flight op and all queued results. No writeback occurs for them.
- issue_ready = ~inflight & ~capture_pending & (count < DEPTH). Combinational from registered state only.
- Issue accept: issue_valid & issue_ready sets inflight and stores issue_rd.
  - issue_valid while issue_ready=0 is ignored and sets err.
- Finish: fp_finish while inflight sets capture_pending.
  - fp_finish with inflight=0 is ignored and sets err.
- Capture: on the cycle capture_pending=1, sample fp_result.
  - If stored rd != 0, push {rd, fp_result} at the write pointer.
  - Clear capture_pending and inflight at the end of that cycle.
  - rd = 0 results are discarded (no push, no writeback).
  - Space is guaranteed, because issue required count < DEPTH and nothing else pushes.
- Drain: wb_en = (count != 0) & ~wb_port_busy. wb_addr/wb_data come from the head entry. On wb_en, pop (read pointer +1 mod DEPTH).
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Latency, unblocked: fp_finish at cycle N, capture at N+1, wb_en at N+2.
- Queue ordering is strictly FIFO. Two queued writes to the same rd retire in order, so the later one wins.
- dep_stall = 1 when rsX != 0 and rsX matches any of:
  - the in-flight rd (while inflight=1), or
  - any valid queue entry's rd (count-qualified, pointer-relative).
  - The entry being popped this cycle still counts, i.e. no write-to-read bypass.
- A writeback to an x0 destination is impossible by construction.
- err is sticky until rst.

Test Plan:
- Basic: issue rd=5; fp_finish at cycle 10; fp_result=0x40400000 at cycle 11 -> wb_en=1, wb_addr=5, wb_data=0x40400000 at cycle 12 only. dep_stall=1 for rs1=5 from cycle 1 through cycle 12, 0 at cycle 13.
- Port contention: same as Basic but wb_port_busy=1 for cycles 12-14 -> wb_en=0 for cycles 12-14, wb_en=1 at cycle 15. issue_ready=1 from cycle 12 (count=1 < 2).
- Queue full (DEPTH=2): busy held high; complete rd=3 (data 0x3F800000) then rd=4 (data 0x40000000) -> issue_ready=0 with count=2. Release busy -> writebacks 3 then 4 on consecutive cycles, and issue_ready returns to 1.
- x0 destination: issue rd=0, finish, result 0x12345678 -> no wb_en. dep_stall stays 0 for rs1=0 throughout.
- Errors: fp_finish with nothing in flight; issue_valid while in flight -> err=1 and state unchanged (count, inflight rd); err remains 1 until rst.
- Reset mid-op: rd=7 in flight plus one queued entry, assert rst for one cycle -> next cycle wb_en=0, dep_stall=0 for rs1=7, issue_ready=1, err=0. A following fp_finish sets err.

Source files
------------

// File: rtl/fp_wb_ctl_if.sv
// Signal bundle between the FP writeback/scoreboard stage and its neighbours:
// issue, execute finish/result, register-file write port and decode source lookup.
interface fp_wb_ctl_if #(
  parameter int AW = 5
);
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic          fp_finish;
  logic [31:0]   fp_result;
  logic          wb_port_busy;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_data;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          dep_stall;
  logic          err;

  modport slave (
    input  issue_valid, issue_rd, fp_finish, fp_result, wb_port_busy,
           rs1_addr, rs2_addr,
    output issue_ready, wb_en, wb_addr, wb_data, dep_stall, err
  );

  modport master (
    output issue_valid, issue_rd, fp_finish, fp_result, wb_port_busy,
           rs1_addr, rs2_addr,
    input  issue_ready, wb_en, wb_addr, wb_data, dep_stall, err
  );
endinterface

// File: rtl/fp_wb_ctl.sv
// FP writeback stage: tracks the single in-flight FP op, queues its result and
// drains the queue into the shared register-file write port when it is free.
module fp_wb_ctl #(
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic         clk,
  input  logic         rst,
  fp_wb_ctl_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          inflight_q, inflight_d;
  logic          cap_q, cap_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [AW-1:0] inflight_rd_q;
  logic [AW-1:0] rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic          issue_ready;
  logic          issue_ok;
  logic          fin_ok;
  logic          push;
  logic          pop;
  logic          dep;
  logic [PW-1:0] off;

  always_comb begin
    issue_ready = ~inflight_q & ~cap_q & (count_q < DEPTH_C);
    issue_ok    = bus.issue_valid & issue_ready;
    // A second finish while the first is still being captured is also a protocol error.
    fin_ok      = bus.fp_finish & inflight_q & ~cap_q;
    push        = cap_q & (inflight_rd_q != '0);
    pop         = (count_q != '0) & ~bus.wb_port_busy;

    inflight_d = inflight_q;
    cap_d      = cap_q;
    if (cap_q) begin
      inflight_d = 1'b0;
      cap_d      = 1'b0;
    end
    if (fin_ok)   cap_d      = 1'b1;
    if (issue_ok) inflight_d = 1'b1;

    err_d = err_q | (bus.issue_valid & ~issue_ready) | (bus.fp_finish & ~fin_ok);

    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Hazard lookup: in-flight rd plus every occupied queue slot, head entry included.
  always_comb begin
    dep = 1'b0;
    off = '0;
    if (inflight_q && bus.rs1_addr != '0 && inflight_rd_q == bus.rs1_addr) dep = 1'b1;
    if (inflight_q && bus.rs2_addr != '0 && inflight_rd_q == bus.rs2_addr) dep = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      off = PW'(j) - rptr_q;
      if ({1'b0, off} < count_q) begin
        if (bus.rs1_addr != '0 && rd_mem_q[j] == bus.rs1_addr) dep = 1'b1;
        if (bus.rs2_addr != '0 && rd_mem_q[j] == bus.rs2_addr) dep = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      cap_q      <= 1'b0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      cap_q      <= cap_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_ok) inflight_rd_q <= bus.issue_rd;
    if (push) begin
      rd_mem_q[wptr_q]   <= inflight_rd_q;
      data_mem_q[wptr_q] <= bus.fp_result;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.wb_en       = pop;
  assign bus.wb_addr     = rd_mem_q[rptr_q];
  assign bus.wb_data     = data_mem_q[rptr_q];
  assign bus.dep_stall   = dep;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_fp_wb_ctl.sv
// Bench for fp_wb_ctl: directed vector table, hand-written multi-cycle corner cases
// and randomized traffic checked against a queue-based reference model.
module tb_fp_wb_ctl;
  localparam int DEPTH = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_wb_ctl_if #(.AW(AW)) bus ();

  fp_wb_ctl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        fin;
    logic [31:0] res;
    logic        busy;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rdy;
    logic        wb;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        dep;
    logic        err;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  vec_t tbl[$];

  // reference model state
  bit         m_inf, m_cap, m_err;
  logic [4:0] m_rd;
  ent_t       m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic iv, input logic [4:0] ird, input logic fin,
                        input logic [31:0] res, input logic busy,
                        input logic [4:0] r1, input logic [4:0] r2);
    bus.issue_valid  = iv;
    bus.issue_rd     = ird;
    bus.fp_finish    = fin;
    bus.fp_result    = res;
    bus.wb_port_busy = busy;
    bus.rs1_addr     = r1;
    bus.rs2_addr     = r2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    adv();
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [4:0] rd, input logic [31:0] data, input logic busy);
    set_in(1, rd, 0, 0, busy, 0, 0);    adv();
    set_in(0, 0, 1, 0, busy, 0, 0);     adv();
    set_in(0, 0, 0, data, busy, 0, 0);  adv();
  endtask

  function automatic vec_t mk(input logic iv, input logic [4:0] ird, input logic fin,
                              input logic [31:0] res, input logic busy,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic rdy, input logic wb, input logic [4:0] addr,
                              input logic [31:0] data, input logic dep, input logic err);
    vec_t v;
    v.iv = iv; v.ird = ird; v.fin = fin; v.res = res; v.busy = busy;
    v.rs1 = rs1; v.rs2 = rs2; v.rdy = rdy; v.wb = wb; v.addr = addr;
    v.data = data; v.dep = dep; v.err = err;
    return v;
  endfunction

  function automatic bit model_dep(input logic [4:0] rs);
    if (rs == 0) return 1'b0;
    if (m_inf && m_rd == rs) return 1'b1;
    foreach (m_q[i]) if (m_q[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    bit         e_rdy, e_wb, e_dep, n_err, old_inf, old_cap;
    logic       iv, fin, busy;
    logic [4:0] ird, r1, r2;
    logic [31:0] res;

    // Basic: issue rd=5 at cycle 0, finish at 10, result at 11, writeback at 12
    tbl.push_back(mk(1, 5, 0, 0, 0, 5, 0,  1, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 9; c++) tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 5, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h40400000, 0, 5, 0,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,             1, 1, 5, 32'h40400000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,             1, 0, 0, 0, 0, 0));
    // x0 destination: result dropped, rs=0 never stalls
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,             1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h12345678, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 0, 0, 0, 0, 0));

    set_in(0, 0, 0, 0, 0, 0, 0);
    adv();
    do_reset();
    @(negedge clk);
    chk("reset_issue_ready", bus.issue_ready, 1);
    chk("reset_wb_en", bus.wb_en, 0);
    chk("reset_dep_stall", bus.dep_stall, 0);
    chk("reset_err", bus.err, 0);
    adv();

    foreach (tbl[i]) begin
      set_in(tbl[i].iv, tbl[i].ird, tbl[i].fin, tbl[i].res, tbl[i].busy, tbl[i].rs1, tbl[i].rs2);
      @(negedge clk);
      chk($sformatf("tbl%0d_issue_ready", i), bus.issue_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_wb_en", i), bus.wb_en, tbl[i].wb);
      chk($sformatf("tbl%0d_dep_stall", i), bus.dep_stall, tbl[i].dep);
      chk($sformatf("tbl%0d_err", i), bus.err, tbl[i].err);
      if (tbl[i].wb) begin
        chk($sformatf("tbl%0d_wb_addr", i), bus.wb_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_wb_data", i), bus.wb_data, tbl[i].data);
      end
      adv();
    end

    // Port contention: write port busy for cycles 12-14
    do_reset();
    set_in(1, 5, 0, 0, 0, 5, 0); adv();
    for (int c = 1; c <= 9; c++) begin set_in(0, 0, 0, 0, 0, 5, 0); adv(); end
    set_in(0, 0, 1, 0, 0, 5, 0); adv();
    set_in(0, 0, 0, 32'h40400000, 0, 5, 0); adv();
    for (int c = 12; c <= 14; c++) begin
      set_in(0, 0, 0, 0, 1, 5, 0);
      @(negedge clk);
      chk("busy_wb_en", bus.wb_en, 0);
      chk("busy_issue_ready", bus.issue_ready, 1);
      chk("busy_dep_stall", bus.dep_stall, 1);
      adv();
    end
    set_in(0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    chk("busy_release_wb_en", bus.wb_en, 1);
    chk("busy_release_wb_addr", bus.wb_addr, 5);
    chk("busy_release_wb_data", bus.wb_data, 32'h40400000);
    adv();
    @(negedge clk);
    chk("busy_after_wb_en", bus.wb_en, 0);
    chk("busy_after_dep", bus.dep_stall, 0);
    adv();

    // Queue full: two results parked behind a busy port, then drained in order
    do_reset();
    run_op(3, 32'h3F800000, 1);
    run_op(4, 32'h40000000, 1);
    set_in(0, 0, 0, 0, 1, 3, 4);
    @(negedge clk);
    chk("full_issue_ready", bus.issue_ready, 0);
    chk("full_wb_en", bus.wb_en, 0);
    chk("full_dep", bus.dep_stall, 1);
    adv();
    set_in(0, 0, 0, 0, 0, 3, 4);
    @(negedge clk);
    chk("full_wb0_en", bus.wb_en, 1);
    chk("full_wb0_addr", bus.wb_addr, 3);
    chk("full_wb0_data", bus.wb_data, 32'h3F800000);
    chk("full_wb0_ready", bus.issue_ready, 0);
    adv();
    @(negedge clk);
    chk("full_wb1_en", bus.wb_en, 1);
    chk("full_wb1_addr", bus.wb_addr, 4);
    chk("full_wb1_data", bus.wb_data, 32'h40000000);
    chk("full_wb1_ready", bus.issue_ready, 1);
    adv();
    @(negedge clk);
    chk("full_empty_wb_en", bus.wb_en, 0);
    chk("full_empty_ready", bus.issue_ready, 1);
    chk("full_empty_dep", bus.dep_stall, 0);
    adv();

    // Protocol errors leave the scoreboard untouched
    do_reset();
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("err_before", bus.err, 0);
    adv();
    set_in(1, 9, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("err_stray_finish", bus.err, 1);
    chk("err_stray_finish_ready", bus.issue_ready, 1);
    adv();
    set_in(1, 11, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("err_busy_issue_ready", bus.issue_ready, 0);
    adv();
    set_in(0, 0, 0, 0, 0, 11, 0);
    @(negedge clk);
    chk("err_rd_not_replaced", bus.dep_stall, 0);
    chk("err_sticky0", bus.err, 1);
    adv();
    set_in(0, 0, 0, 0, 0, 9, 0);
    @(negedge clk);
    chk("err_rd_kept", bus.dep_stall, 1);
    adv();
    set_in(0, 0, 1, 0, 0, 0, 0); adv();
    set_in(0, 0, 0, 32'hC0000000, 0, 0, 0); adv();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("err_wb_en", bus.wb_en, 1);
    chk("err_wb_addr", bus.wb_addr, 9);
    chk("err_wb_data", bus.wb_data, 32'hC0000000);
    adv();
    @(negedge clk);
    chk("err_single_wb", bus.wb_en, 0);
    chk("err_sticky1", bus.err, 1);
    adv();
    do_reset();
    @(negedge clk);
    chk("err_cleared", bus.err, 0);
    adv();

    // Reset mid-operation: one queued entry plus one in flight
    run_op(6, 32'hAAAA5555, 1);
    set_in(1, 7, 0, 0, 1, 0, 0); adv();
    set_in(0, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 7, 6);
    @(negedge clk);
    chk("rstmid_wb_en", bus.wb_en, 0);
    chk("rstmid_dep", bus.dep_stall, 0);
    chk("rstmid_ready", bus.issue_ready, 1);
    chk("rstmid_err", bus.err, 0);
    adv();
    set_in(0, 0, 1, 0, 0, 0, 0); adv();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstmid_finish_err", bus.err, 1);
    chk("rstmid_no_wb", bus.wb_en, 0);
    adv();

    // Randomized traffic against the reference model
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      m_inf = 0; m_cap = 0; m_err = 0; m_rd = 0;
      m_q.delete();
      for (int n = 0; n < 800; n++) begin
        e_rdy = !m_inf && !m_cap && (m_q.size() < DEPTH);
        busy  = ($urandom_range(0, 2) == 0);
        iv    = e_rdy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
        ird   = 5'($urandom_range(0, 7));
        if (m_inf && !m_cap) fin = ($urandom_range(0, 3) == 0);
        else                 fin = !m_inf && ($urandom_range(0, 299) == 0);
        res   = $urandom;
        r1    = 5'($urandom_range(0, 7));
        r2    = 5'($urandom_range(0, 7));
        set_in(iv, ird, fin, res, busy, r1, r2);

        e_wb  = (m_q.size() != 0) && !busy;
        e_dep = model_dep(r1) || model_dep(r2);
        @(negedge clk);
        chk("rnd_issue_ready", bus.issue_ready, e_rdy);
        chk("rnd_wb_en", bus.wb_en, e_wb);
        chk("rnd_dep_stall", bus.dep_stall, e_dep);
        chk("rnd_err", bus.err, m_err);
        if (e_wb) begin
          chk("rnd_wb_addr", bus.wb_addr, m_q[0].rd);
          chk("rnd_wb_data", bus.wb_data, m_q[0].d);
        end
        adv();

        old_inf = m_inf;
        old_cap = m_cap;
        n_err = m_err || (iv && !e_rdy) || (fin && !(old_inf && !old_cap));
        if (e_wb) void'(m_q.pop_front());
        if (old_cap) begin
          if (m_rd != 0) m_q.push_back('{rd: m_rd, d: res});
          m_inf = 0;
          m_cap = 0;
        end
        if (fin && old_inf && !old_cap) m_cap = 1;
        if (iv && e_rdy) begin
          m_inf = 1;
          m_rd  = ird;
        end
        m_err = n_err;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
